// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out word assembler with frame resynchronisation.
// Bits shift in at the MSB, so the first bit received ends up in the LSB of par_out.
module sipo_deserializer #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sof,
    input  logic          sin_vld,
    input  logic          sin,
    output logic [DW-1:0] par_out,
    output logic          par_vld,
    output logic          busy,
    output logic          frm_err
);

    localparam int              CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(DW - 1);

    logic [DW-1:0] r_shreg;
    logic [DW-1:0] r_par_out;
    logic [CW-1:0] r_cnt;
    logic          r_par_vld;
    logic          r_frm_err;

    logic [DW-1:0] w_shifted;
    logic [CW-1:0] w_base_cnt;
    logic          w_last;

    generate
        if (DW == 1) begin : g_narrow
            assign w_shifted = sin;
        end else begin : g_wide
            assign w_shifted = {sin, r_shreg[DW-1:1]};
        end
    endgenerate

    // A bit arriving with sof restarts the count, so it is treated as bit 0 of a fresh word.
    assign w_base_cnt = sof ? '0 : r_cnt;
    assign w_last     = (w_base_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_par_out <= '0;
            r_cnt     <= '0;
            r_par_vld <= 1'b0;
            r_frm_err <= 1'b0;
        end else if (clr) begin
            r_shreg   <= '0;
            r_par_out <= '0;
            r_cnt     <= '0;
            r_par_vld <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_par_vld <= 1'b0;
            r_frm_err <= sof && (r_cnt != '0);
            if (sin_vld) begin
                r_shreg <= w_shifted;
                if (w_last) begin
                    r_par_out <= w_shifted;
                    r_par_vld <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= w_base_cnt + CW'(1);
                end
            end else if (sof) begin
                r_cnt <= '0;
            end
        end
    end

    assign par_out = r_par_out;
    assign par_vld = r_par_vld;
    assign frm_err = r_frm_err;
    assign busy    = (r_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomised and directed bench for sipo_deserializer with a queue-based reference model
// and a scoreboard monitor; a second DW=1 instance covers the single-bit word case.
module tb_sipo_deserializer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr, sof, sinVld, sin;
    logic [DW-1:0] parOut;
    logic          parVld, busy, frmErr;

    logic          clr1, sof1, sinVld1, sin1;
    logic [0:0]    parOut1;
    logic          parVld1, busy1, frmErr1;

    int checks   = 0;
    int failures = 0;

    // Reference model: partial word as a bit list, completed words queued for the monitor
    bit            partial[$];
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] modelParOut = '0;
    bit            pendVld = 0, pendErr = 0;
    bit            expBusy = 0, expVld = 0, expErr = 0;
    logic [DW-1:0] expParOut = '0;
    bit            checkOn = 0;

    sipo_deserializer #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .sof(sof), .sin_vld(sinVld), .sin(sin),
        .par_out(parOut), .par_vld(parVld), .busy(busy), .frm_err(frmErr)
    );

    sipo_deserializer #(.DW(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .sof(sof1), .sin_vld(sinVld1), .sin(sin1),
        .par_out(parOut1), .par_vld(parVld1), .busy(busy1), .frm_err(frmErr1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances to the state after the coming edge
    task automatic applyStimulus(input bit iClr, input bit iSof, input bit iVld, input bit iBit);
        logic [DW-1:0] word;
        @(posedge clk);
        #1;
        expBusy   = (partial.size() != 0);
        expParOut = modelParOut;
        expVld    = pendVld;
        expErr    = pendErr;
        pendVld   = 0;
        pendErr   = 0;
        checkOn   = 1;
        clr = iClr; sof = iSof; sinVld = iVld; sin = iBit;
        if (iClr) begin
            partial.delete();
            modelParOut = '0;
        end else begin
            if (iSof) begin
                if (partial.size() != 0) pendErr = 1;
                partial.delete();
            end
            if (iVld) begin
                partial.push_back(iBit);
                if (partial.size() == DW) begin
                    word = '0;
                    for (int i = 0; i < DW; i++) word[i] = partial[i];
                    expQ.push_back(word);
                    modelParOut = word;
                    pendVld = 1;
                    partial.delete();
                end
            end
        end
    endtask

    task automatic sendWord(input logic [DW-1:0] w, input int maxGap);
        for (int i = 0; i < DW; i++) begin
            repeat ($urandom_range(0, maxGap)) applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 1, w[i]);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn && rst) begin
            checkOutput("busy", busy, expBusy);
            checkOutput("par_out hold", parOut, expParOut);
            checkOutput("par_vld", parVld, expVld);
            checkOutput("frm_err", frmErr, expErr);
            if (parVld) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected word", parOut, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("word", parOut, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        bit [2:0] pat1 = 3'b101;
        rst = 0; clr = 0; sof = 0; sinVld = 0; sin = 0;
        clr1 = 0; sof1 = 0; sinVld1 = 0; sin1 = 0;
        @(negedge clk);
        checkOutput("reset par_out", parOut, 0);
        checkOutput("reset par_vld", parVld, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frm_err", frmErr, 0);
        @(posedge clk);
        #1 rst = 1;

        // Single word 1,0,1,1 -> 4'hD
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Streaming with random gaps
        sendWord(4'hA, 3);
        sendWord(4'h5, 3);
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Resync: three bits, then sof with bits 0,0,1,0 -> 4'h4
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // clr on the 4th bit, then sof with nothing in progress
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Asynchronous reset mid-word (cnt=2)
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("busy before reset", busy, 1);
        #2;
        checkOn = 0;
        rst = 0;
        #1;
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset par_out", parOut, 0);
        checkOutput("async reset par_vld", parVld, 0);
        partial.delete();
        modelParOut = '0;
        pendVld = 0;
        pendErr = 0;
        @(posedge clk);
        #1 rst = 1;
        sendWord(4'h9, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            applyStimulus(r < 2, (r >= 2) && (r < 8), $urandom_range(0, 3) != 0, 1'($urandom));
        end
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOn = 0;
        checkOutput("scoreboard drained", expQ.size(), 0);

        // DW=1 instance: continuous bits 1,0,1
        @(posedge clk);
        #1; sinVld1 = 1; sin1 = pat1[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) sin1 = pat1[i+1];
            else sinVld1 = 0;
            @(negedge clk);
            checkOutput("dw1 par_vld", parVld1, 1);
            checkOutput("dw1 par_out", parOut1, pat1[i]);
            checkOutput("dw1 busy", busy1, 0);
        end
        @(negedge clk);
        checkOutput("dw1 par_vld drop", parVld1, 0);
        checkOutput("dw1 par_out hold", parOut1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
